// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: the decode-side inputs, the writeback snoop/bypass port,
// the stall/flush controls and the registered EX-stage copies.
interface id_ex_stage_if #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 32
);
  logic              Valid_in;
  logic [63:0]       BusA_in;
  logic [63:0]       BusB_in;
  logic [4:0]        RA_in;
  logic [4:0]        RB_in;
  logic [4:0]        RW_in;
  logic [63:0]       Imm_in;
  logic [63:0]       PC_in;
  logic [CTRL_W-1:0] Ctrl_in;
  logic              MemRead_in;
  logic              RegWr_in;
  logic              WB_RegWr;
  logic [4:0]        WB_RW;
  logic [63:0]       WB_BusW;
  logic              Hold;
  logic              Flush;

  logic              LoadUse_stall;
  logic              Valid_out;
  logic [63:0]       BusA_out;
  logic [63:0]       BusB_out;
  logic [4:0]        RA_out;
  logic [4:0]        RB_out;
  logic [4:0]        RW_out;
  logic [63:0]       Imm_out;
  logic [63:0]       PC_out;
  logic [CTRL_W-1:0] Ctrl_out;
  logic              MemRead_out;
  logic              RegWr_out;
  logic [CNT_W-1:0]  Bubble_cnt;

  // Decode/writeback side: drives the stage inputs, observes the EX copies.
  modport master (
    output Valid_in, BusA_in, BusB_in, RA_in, RB_in, RW_in, Imm_in, PC_in,
           Ctrl_in, MemRead_in, RegWr_in, WB_RegWr, WB_RW, WB_BusW, Hold, Flush,
    input  LoadUse_stall, Valid_out, BusA_out, BusB_out, RA_out, RB_out,
           RW_out, Imm_out, PC_out, Ctrl_out, MemRead_out, RegWr_out, Bubble_cnt
  );

  // The pipeline register itself.
  modport slave (
    input  Valid_in, BusA_in, BusB_in, RA_in, RB_in, RW_in, Imm_in, PC_in,
           Ctrl_in, MemRead_in, RegWr_in, WB_RegWr, WB_RW, WB_BusW, Hold, Flush,
    output LoadUse_stall, Valid_out, BusA_out, BusB_out, RA_out, RB_out,
           RW_out, Imm_out, PC_out, Ctrl_out, MemRead_out, RegWr_out, Bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands, bypasses same-cycle
// writeback data, snoops writeback while held, and inserts/counts load-use
// bubbles. X31 is the zero register and never matches any compare.
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 32
) (
  input logic           Clk,
  input logic           Rst_n,
  id_ex_stage_if.slave  bus
);

  localparam logic [4:0] XZR = 5'd31;

  logic        wb_live;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        stall;
  logic        snoop_a;
  logic        snoop_b;

  // Writeback bypass for the decode operands and load-use hazard detection.
  always_comb begin
    wb_live = bus.WB_RegWr && (bus.WB_RW != XZR);
    op_a    = (wb_live && (bus.WB_RW == bus.RA_in)) ? bus.WB_BusW : bus.BusA_in;
    op_b    = (wb_live && (bus.WB_RW == bus.RB_in)) ? bus.WB_BusW : bus.BusB_in;
    snoop_a = wb_live && (bus.WB_RW == bus.RA_out);
    snoop_b = wb_live && (bus.WB_RW == bus.RB_out);
    stall   = bus.Valid_in && bus.Valid_out && bus.MemRead_out &&
              (bus.RW_out != XZR) &&
              ((bus.RW_out == bus.RA_in) || (bus.RW_out == bus.RB_in)) &&
              !bus.Flush && !bus.Hold;
  end

  assign bus.LoadUse_stall = stall;

  // Pipeline register: flush > hold (with snoop) > load-use bubble > load.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bus.Valid_out   <= 1'b0;
      bus.BusA_out    <= '0;
      bus.BusB_out    <= '0;
      bus.RA_out      <= '0;
      bus.RB_out      <= '0;
      bus.RW_out      <= '0;
      bus.Imm_out     <= '0;
      bus.PC_out      <= '0;
      bus.Ctrl_out    <= '0;
      bus.MemRead_out <= 1'b0;
      bus.RegWr_out   <= 1'b0;
    end else if (bus.Flush || (!bus.Hold && stall)) begin
      bus.Valid_out   <= 1'b0;
      bus.BusA_out    <= '0;
      bus.BusB_out    <= '0;
      bus.RA_out      <= '0;
      bus.RB_out      <= '0;
      bus.RW_out      <= '0;
      bus.Imm_out     <= '0;
      bus.PC_out      <= '0;
      bus.Ctrl_out    <= '0;
      bus.MemRead_out <= 1'b0;
      bus.RegWr_out   <= 1'b0;
    end else if (bus.Hold) begin
      if (snoop_a) bus.BusA_out <= bus.WB_BusW;
      if (snoop_b) bus.BusB_out <= bus.WB_BusW;
    end else begin
      bus.Valid_out   <= bus.Valid_in;
      bus.BusA_out    <= op_a;
      bus.BusB_out    <= op_b;
      bus.RA_out      <= bus.RA_in;
      bus.RB_out      <= bus.RB_in;
      bus.RW_out      <= bus.RW_in;
      bus.Imm_out     <= bus.Imm_in;
      bus.PC_out      <= bus.PC_in;
      bus.Ctrl_out    <= bus.Ctrl_in;
      bus.MemRead_out <= bus.Valid_in && bus.MemRead_in;
      bus.RegWr_out   <= bus.Valid_in && bus.RegWr_in;
    end
  end

  // Saturating count of load-use bubbles actually inserted.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bus.Bubble_cnt <= '0;
    end else if (!bus.Flush && !bus.Hold && stall && (bus.Bubble_cnt != '1)) begin
      bus.Bubble_cnt <= bus.Bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly downstream of the register file, between decode and execute.
- Latches decoded operands, immediates, PC and control.
- Bypasses same-cycle writeback data around the register file's read-before-write, and snoops writeback while held.
- Detects load-use hazards, inserts bubbles, and counts them.

Parameters:
CTRL_W, 8, width of opaque EX/MEM/WB control bundle passed through unchanged
CNT_W, 32, width of saturating bubble counter

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst_n  in  1  asynchronous active-low reset
Valid_in  in  1  decode holds a real instruction
BusA_in  in  64  register file read port A data
BusB_in  in  64  register file read port B data
RA_in  in  5  source register A number
RB_in  in  5  source register B number
RW_in  in  5  destination register number
Imm_in  in  64  sign-extended immediate
PC_in  in  64  instruction PC
Ctrl_in  in  CTRL_W  control bundle
MemRead_in  in  1  instruction is a load
RegWr_in  in  1  instruction writes a register
WB_RegWr  in  1  writeback stage writing this cycle
WB_RW  in  5  writeback destination
WB_BusW  in  64  writeback data
Hold  in  1  downstream stall: freeze stage
Flush  in  1  branch redirect: squash stage
LoadUse_stall  out  1  combinational: IF/ID must hold this cycle
Valid_out, BusA_out, BusB_out, RA_out, RB_out, RW_out, Imm_out, PC_out, Ctrl_out, MemRead_out, RegWr_out  out  widths as inputs  registered EX-stage copies
Bubble_cnt  out  CNT_W  number of load-use bubbles inserted

Behaviour:
- Reset (async, Rst_n=0): all outputs 0, including Valid_out, RegWr_out, MemRead_out and Bubble_cnt. Takes effect immediately, mid-operation included.
- Register X31 reads as zero; X31 never matches in bypass, snoop or hazard compare.
- Bypass, combinational: opA = (WB_RegWr && WB_RW==RA_in && RA_in!=31) ? WB_BusW : BusA_in. opB is identical using RB_in and BusB_in.
- LoadUse_stall = Valid_in && Valid_out && MemRead_out && RW_out!=31 && (RW_out==RA_in || RW_out==RB_in) && !Flush && !Hold.
- Per rising edge, priority order:
  1. Flush=1: bubble. Valid_out, RegWr_out, MemRead_out and Ctrl_out cleared to 0; other fields don't-care, but implementation must zero them.
  2. Hold=1: all fields keep their value (snoop rule applies).
  3. LoadUse_stall=1: bubble as in Flush; Bubble_cnt increments.
  4. Otherwise: load all _in fields. BusA_out=opA, BusB_out=opB. Valid_out=Valid_in. If Valid_in=0, RegWr_out and MemRead_out load as 0.
- Snoop during Hold: if WB_RegWr && WB_RW!=31, then WB_RW==RA_out updates BusA_out to WB_BusW, and WB_RW==RB_out updates BusB_out. Both are updated if both match.
- Bubble_cnt saturates at all-ones; it does not wrap.
- Latency: 1 cycle input-to-output. A load-use pair yields exactly one bubble.
- A bubble with Valid_in=1 leaves the dependent instruction in decode; the next edge loads it with the load's WB result bypassed or snooped downstream.
- Simultaneous Flush and Hold: Flush wins.
- LoadUse_stall is forced 0 during Flush or Hold.

Test Plan:
- Reset mid-stream: load PC_in=0x40 and Valid_in=1, then pulse Rst_n low between edges -> all outputs 0 immediately, Bubble_cnt=0.
- WB bypass: RA_in=3, BusA_in=0x11, WB_RegWr=1, WB_RW=3, WB_BusW=0xAB -> BusA_out=0xAB after the edge. Same stimulus with RA_in=31 and WB_RW=31 -> BusA_out=BusA_in.
- Load-use: LDUR X5 latched (MemRead_out=1, RW_out=5), decode ADD with RA_in=5 ->
  - LoadUse_stall=1.
  - Next edge: Valid_out=0, Bubble_cnt=1.
  - Following edge: ADD latched with RA_out=5.
  - Dependency on X31 -> no stall.
- Hold with snoop: Hold=1 for 3 cycles with RB_out=7 and WB_RW=7 / WB_BusW=0x99 in cycle 2 -> all other fields unchanged, BusB_out=0x99.
- Flush priority: Flush=1 and Hold=1 with a valid load present -> Valid_out=0, MemRead_out=0; Bubble_cnt unchanged.
- Saturation: CNT_W=4, force 17 load-use bubbles -> Bubble_cnt=15.
